// File: rtl/round_ctrl.sv
// Round sequencer for the two-player push-button duel: re-arms the button latch,
// walks the one-hot position light toward each round winner and flags a game win.
module round_ctrl #(
    parameter int NLEDS    = 9,
    parameter int HOLD_CYC = 1000,
    parameter int RW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             winrnd,
    input  logic             right,
    input  logic             tie,
    output logic             clr,
    output logic [NLEDS-1:0] leds,
    output logic             winner_l,
    output logic             winner_r,
    output logic             busy,
    output logic [RW-1:0]    rounds
);

    localparam int PW = $clog2(NLEDS);
    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [PW-1:0] CENTRE = PW'((NLEDS - 1) / 2);
    localparam logic [PW-1:0] RIGHT_END = PW'(NLEDS - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ARMED, GAMEOVER} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pos, pos_step;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          new_game;
    logic          end_r, end_l;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        pos_step = pos;
        accept   = (state == ARMED) && winrnd;
        new_game = (state == GAMEOVER) && start;

        if (!tie) begin
            pos_step = right ? pos + 1'b1 : pos - 1'b1;
        end
        end_r = !tie && (pos_step == RIGHT_END);
        end_l = !tie && (pos_step == '0);

        case (state)
            IDLE:     if (start) state_nx = SETTLE;
            SETTLE:   if (cnt == HOLD_LAST) state_nx = ARMED;
            ARMED:    if (winrnd) state_nx = (end_r || end_l) ? GAMEOVER : SETTLE;
            GAMEOVER: if (start) state_nx = SETTLE;
            default:  state_nx = IDLE;
        endcase
    end

    // NOTE: all state and output registers are reset asynchronously so the latch is cleared the instant rst drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pos      <= CENTRE;
            cnt      <= '0;
            clr      <= 1'b1;
            winner_l <= 1'b0;
            winner_r <= 1'b0;
            rounds   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
            clr   <= (state_nx != ARMED);

            // Counter idles at zero outside SETTLE, so every SETTLE entry starts a fresh hold.
            if (state == SETTLE) cnt <= cnt + 1'b1;
            else                 cnt <= '0;

            if (accept) begin
                pos <= pos_step;
                if (rounds != '1) rounds <= rounds + 1'b1;
                if (end_r) winner_r <= 1'b1;
                if (end_l) winner_l <= 1'b1;
            end else if (new_game) begin
                pos      <= CENTRE;
                rounds   <= '0;
                winner_l <= 1'b0;
                winner_r <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = (state != IDLE);
        leds = NLEDS'(1) << pos;
    end

endmodule
